// File: rtl/packing_aggregator_if.sv
// Sender/receiver FIFO handshake bundle for packing_aggregator.
// master drives the sender words and receiver status; slave is the packer.
interface packing_aggregator_if #(
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned MAX_FETCH_WIDTH = 6
);
   localparam int unsigned FW_W = $clog2(MAX_FETCH_WIDTH + 1);

   logic [DATA_WIDTH-1:0]                 sender_data;
   logic                                  sender_empty_n;
   logic                                  sender_deq;
   logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data;
   logic [FW_W-1:0]                       receiver_count;
   logic                                  receiver_full_n;
   logic                                  receiver_enq;
   logic                                  change_fetch_width;
   logic [FW_W-1:0]                       input_fetch_width;
   logic                                  flush;

   modport master (
      output sender_data, sender_empty_n, receiver_full_n,
      output change_fetch_width, input_fetch_width, flush,
      input  sender_deq, receiver_data, receiver_count, receiver_enq
   );

   modport slave (
      input  sender_data, sender_empty_n, receiver_full_n,
      input  change_fetch_width, input_fetch_width, flush,
      output sender_deq, receiver_data, receiver_count, receiver_enq
   );
endinterface

// File: rtl/packing_aggregator.sv
// Serial-to-parallel packer: gathers sender words into multi-lane beats with a
// runtime lane count, optional flush of a partial beat, and a registered output stage.
module packing_aggregator #(
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned MAX_FETCH_WIDTH = 6
) (
   input logic                 clk,
   input logic                 rst,
   packing_aggregator_if.slave bus
);
   localparam int unsigned     FW_W   = $clog2(MAX_FETCH_WIDTH + 1);
   localparam logic [FW_W-1:0] FW_MAX = FW_W'(MAX_FETCH_WIDTH);

   logic [FW_W-1:0]                       fw_r, fw_pend_r, count_r, out_cnt_r;
   logic                                  pend_vld_r, out_vld_r;
   logic [DATA_WIDTH-1:0]                 asm_r [MAX_FETCH_WIDTH];
   logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] out_r;

   logic                                  last_lane, blocked, accept, close, fire;
   logic                                  apply_pend, enq;
   logic [FW_W-1:0]                       close_cnt, req_fw;
   logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] beat;

   // Handshake decode, beat assembly and width-request clamping.
   always_comb begin
      last_lane = (count_r == fw_r - 1'b1);
      blocked   = out_vld_r & ~bus.receiver_full_n;
      // A word that would close a beat cannot be taken while the output stage is stuck.
      accept    = ~rst & bus.sender_empty_n & ~(blocked & (last_lane | bus.flush));
      close     = (last_lane & accept) | (bus.flush & ((count_r != '0) | accept));
      // Flush against a stalled output stage does nothing; the caller keeps flush high.
      fire      = close & ~blocked;
      close_cnt = count_r + FW_W'(accept);
      enq       = ~rst & out_vld_r & bus.receiver_full_n;
      // Width changes only land between beats, never while a word enters lane 0.
      apply_pend = pend_vld_r & (count_r == '0) & ~accept;
      if ((bus.input_fetch_width == '0) || (bus.input_fetch_width > FW_MAX)) begin
         req_fw = FW_MAX;
      end else begin
         req_fw = bus.input_fetch_width;
      end
      beat = '0;
      for (int unsigned i = 0; i < MAX_FETCH_WIDTH; i++) begin
         if (FW_W'(i) < count_r) begin
            beat[i*DATA_WIDTH +: DATA_WIDTH] = asm_r[i];
         end else if ((FW_W'(i) == count_r) && accept) begin
            beat[i*DATA_WIDTH +: DATA_WIDTH] = bus.sender_data;
         end
      end
   end

   // Drive the interface outputs.
   always_comb begin
      bus.sender_deq     = accept;
      bus.receiver_enq   = enq;
      bus.receiver_data  = out_r;
      bus.receiver_count = out_cnt_r;
   end

   // Active lane count and the pending (latest-wins) width request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fw_r       <= FW_MAX;
         fw_pend_r  <= FW_MAX;
         pend_vld_r <= 1'b0;
      end else begin
         if (apply_pend) begin
            fw_r <= fw_pend_r;
         end
         if (bus.change_fetch_width) begin
            fw_pend_r  <= req_fw;
            pend_vld_r <= 1'b1;
         end else if (apply_pend) begin
            pend_vld_r <= 1'b0;
         end
      end
   end

   // Assembly lanes and fill count; cleared whenever a beat leaves for the output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
         for (int unsigned i = 0; i < MAX_FETCH_WIDTH; i++) begin
            asm_r[i] <= '0;
         end
      end else if (fire) begin
         count_r <= '0;
         for (int unsigned i = 0; i < MAX_FETCH_WIDTH; i++) begin
            asm_r[i] <= '0;
         end
      end else if (accept) begin
         asm_r[count_r] <= bus.sender_data;
         count_r        <= count_r + 1'b1;
      end
   end

   // Registered output beat; a new close while draining keeps the stage full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_r     <= '0;
         out_cnt_r <= '0;
         out_vld_r <= 1'b0;
      end else if (fire) begin
         out_r     <= beat;
         out_cnt_r <= close_cnt;
         out_vld_r <= 1'b1;
      end else if (enq) begin
         out_vld_r <= 1'b0;
      end
   end
endmodule
